imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MEM_BYTES, default 4096; byte capacity of the target instruction memory, power of two.
REQ-002 Parameter ADDR_W, default 32; width of mem_addr.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
REQ-006 byte_valid  input  1  stream byte present.
REQ-007 byte_data  input  8  stream byte.
REQ-008 byte_ready  output  1  loader accepts byte this cycle.
REQ-009 mem_we  output  1  one-cycle word write strobe to instruction memory.
REQ-010 mem_addr  output  ADDR_W  word-aligned byte address of the write (bits [1:0] = 0).
REQ-011 mem_wdata  output  32  assembled word; byte 0 of the group in [7:0], byte 3 in [31:24] (little-endian).
REQ-012 busy  output  1  state is HDR, LOAD or CSUM.
REQ-013 done  output  1  load completed successfully; held until next start or reset.
REQ-014 error  output  1  load aborted; held until next start or reset.
REQ-015 words_loaded  output  ADDR_W  count of words written in current/last load.

Function
REQ-016 A byte is accepted on a rising edge when byte_valid and byte_ready are both 1; byte_ready is 1 exactly in HDR, LOAD, CSUM.
REQ-017 States: IDLE, HDR, LOAD, CSUM, DONE, ERR; start in IDLE/DONE/ERR -> HDR, clears done, error, words_loaded, byte counter, checksum; start while busy is ignored.
REQ-018 HDR: 4 accepted bytes form word count N (little-endian); on the 4th byte: N > MEM_BYTES/4 -> ERR; N = 0 -> CSUM (or DONE without checksum feature); else LOAD.
REQ-019 LOAD: every 4 accepted bytes form one word; mem_we pulses for exactly one cycle the cycle after the 4th byte is accepted, with mem_addr = 4*words_loaded and mem_wdata = assembled word.
REQ-020 words_loaded increments in the same cycle mem_we is asserted; after the Nth word -> CSUM (or DONE).
REQ-021 Accepting one byte per cycle back-to-back is supported with no bubbles; write of word k overlaps acceptance of byte 0 of word k+1.
REQ-022 mem_addr never exceeds MEM_BYTES-4; no wrap-around occurs because REQ-018 rejects oversize N.
REQ-023 mem_we, mem_addr, mem_wdata are 0 whenever no write is issued.
REQ-024 Gaps in byte_valid stall assembly without loss; partial word bytes are retained.

Reset
REQ-025 reset asserted at any time, including mid-load, forces IDLE asynchronously; all outputs 0, byte counter, assembly register, checksum cleared; no mem_we pulse is emitted for a partial word.
REQ-026 After reset release the loader stays in IDLE until start.

Configuration
REQ-027 Macro IMEM_LOADER_CHECKSUM_EN defined: running 32-bit sum (mod 2^32) of all payload words; CSUM accepts 4 further bytes (little-endian); match -> DONE, mismatch -> ERR; written words remain in memory either way.
REQ-028 Macro undefined: no CSUM state, no checksum logic; LOAD -> DONE directly after the Nth word.

Structure
REQ-029 Shared package holds the state enumeration type, header/checksum byte count constant (4) and the little-endian byte-lane constants.
REQ-030 One sub-module, le_word_assembler: shifts accepted bytes into a 32-bit little-endian word and flags word-complete; used for header, payload and checksum.

Verification
REQ-031 Reset mid-LOAD after 2 bytes of word 1 -> no mem_we, busy=0, all outputs 0, next start loads from address 0.
REQ-032 Stream N=2, bytes 13 00 00 00 93 00 10 00 -> writes 0x00000013@0x0, 0x00100093@0x4; done=1, words_loaded=2.
REQ-033 N=0x401 with MEM_BYTES=4096 -> error=1 after 4th header byte, no mem_we.
REQ-034 CHECKSUM_EN, N=2 as above plus checksum bytes A6 00 10 00 -> done=1; checksum bytes A7 00 10 00 -> error=1, both words written.
REQ-035 N=1 with byte_valid toggling every other cycle and start pulsed mid-load -> single correct write, start ignored, done=1.
REQ-036 N=1024 back-to-back bytes -> last write at 0xFFC, 1024 mem_we pulses, no bubbles, done=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader:
//   - state_t       : loader state enumeration
//   - WORD_BYTES    : bytes per header / payload / checksum word (4)
//   - LANE*_LSB     : little-endian byte-lane bit offsets within a 32-bit word
//   - lane_lsb()    : maps a byte index within a word to its lane offset
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds the CSUM state).
// -----------------------------------------------------------------------------
package imem_loader_pkg;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;
`endif

  localparam int WORD_BYTES = 4;
  localparam int LANE_W     = 8;

  // Byte k of a group lands at bit offset LANEk_LSB (little-endian).
  localparam int LANE0_LSB = 0;
  localparam int LANE1_LSB = 8;
  localparam int LANE2_LSB = 16;
  localparam int LANE3_LSB = 24;

  function automatic int lane_lsb(input int lane);
    case (lane)
      0:       return LANE0_LSB;
      1:       return LANE1_LSB;
      2:       return LANE2_LSB;
      default: return LANE3_LSB;
    endcase
  endfunction

endpackage

// File: rtl/imem_loader_le_word_assembler.sv
// -----------------------------------------------------------------------------
// le_word_assembler
// Collects accepted bytes into a 32-bit little-endian word. The first byte of a
// group goes to [7:0], the fourth to [31:24]. On the cycle the fourth byte is
// accepted, 'complete' is high and 'word' already contains that byte, so the
// caller can capture the full word on the same edge without a bubble.
// Ports:
//   clk, reset   clock / asynchronous active-high reset
//   clear        synchronous clear of lane index and lane registers
//   accept       a byte is taken this cycle
//   data[7:0]    byte value
//   word[31:0]   assembled word (stored lanes, incoming byte bypassed in)
//   complete     fourth byte of the group accepted this cycle
// -----------------------------------------------------------------------------
module le_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        complete
);

  logic [1:0] lane_sel_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_sel_reg <= 2'd0;
    end else if (clear) begin
      lane_sel_reg <= 2'd0;
    end else if (accept) begin
      // Wraps naturally from 3 back to 0 at the end of each group.
      lane_sel_reg <= lane_sel_reg + 2'd1;
    end
  end

  assign complete = accept && (lane_sel_reg == 2'(WORD_BYTES - 1));

  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      logic [LANE_W-1:0] lane_reg;
      logic              hit;

      assign hit = accept && (lane_sel_reg == 2'(gi));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          lane_reg <= '0;
        end else if (clear) begin
          lane_reg <= '0;
        end else if (hit) begin
          lane_reg <= data;
        end
      end

      assign word[lane_lsb(gi) +: LANE_W] = hit ? data : lane_reg;
    end
  endgenerate

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Streams a little-endian image into instruction memory. Stream format:
//   4-byte word count N, then N payload words (4 bytes each), then, when
//   IMEM_LOADER_CHECKSUM_EN is defined, a 4-byte sum (mod 2^32) of the payload.
// Oversize N (> MEM_BYTES/4) aborts after the header, so mem_addr never wraps.
// Parameters: MEM_BYTES (power of two), ADDR_W (mem_addr / words_loaded width).
// Ports:
//   clk, reset               clock / asynchronous active-high reset
//   start                    begin a load (honoured in IDLE, DONE, ERR)
//   byte_valid, byte_data    input byte stream
//   byte_ready               byte accepted when byte_valid && byte_ready
//   mem_we/addr/wdata        one-cycle word write; all zero when idle
//   busy, done, error        status (done/error held until next start)
//   words_loaded             words written in the current / last load
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = 4096,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_loaded
);

  localparam logic [31:0] MAX_WORDS = 32'(MEM_BYTES / 4);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_PAYLOAD = ST_CSUM;
`else
  localparam state_t AFTER_PAYLOAD = ST_DONE;
`endif

  state_t      state_reg;
  state_t      state_next;

  logic        accept;
  logic        start_take;
  logic [31:0] asm_word;
  logic        asm_complete;
  logic [31:0] n_reg;
  logic [31:0] word_cnt_reg;
  logic        last_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] csum_reg;
`endif

  assign accept     = byte_valid && byte_ready;
  assign start_take = start && ((state_reg == ST_IDLE) ||
                                (state_reg == ST_DONE) ||
                                (state_reg == ST_ERR));
  // word_cnt_reg counts words already written, so the word completing now is
  // the last one when it brings the count up to N.
  assign last_word  = (word_cnt_reg + 32'd1) == n_reg;

  le_word_assembler u_asm (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_take),
    .accept   (accept),
    .data     (byte_data),
    .word     (asm_word),
    .complete (asm_complete)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_next = ST_HDR;
        end
      end
      ST_HDR: begin
        if (asm_complete) begin
          if (asm_word > MAX_WORDS) begin
            state_next = ST_ERR;
          end else if (asm_word == 32'd0) begin
            state_next = AFTER_PAYLOAD;
          end else begin
            state_next = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (asm_complete && last_word) begin
          state_next = AFTER_PAYLOAD;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (asm_complete) begin
          state_next = (asm_word == csum_reg) ? ST_DONE : ST_ERR;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    error = 1'b0;
    case (state_reg)
      ST_HDR, ST_LOAD: busy = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM:         busy = 1'b1;
`endif
      ST_DONE:         done  = 1'b1;
      ST_ERR:          error = 1'b1;
      default:         busy  = 1'b0;
    endcase
  end

  assign byte_ready   = busy;
  assign words_loaded = ADDR_W'(word_cnt_reg);

  // ---------------------------------------------------------------------------
  // Datapath: word count, write port, running checksum
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      n_reg        <= '0;
      word_cnt_reg <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_reg     <= '0;
`endif
    end else begin
      // Write port is idle-zero unless a word completes this cycle.
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;

      if (start_take) begin
        n_reg        <= '0;
        word_cnt_reg <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_reg     <= '0;
`endif
      end

      if ((state_reg == ST_HDR) && asm_complete) begin
        n_reg <= asm_word;
      end

      if ((state_reg == ST_LOAD) && asm_complete) begin
        mem_we       <= 1'b1;
        mem_addr     <= ADDR_W'({word_cnt_reg[29:0], 2'b00});
        mem_wdata    <= asm_word;
        word_cnt_reg <= word_cnt_reg + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_reg     <= csum_reg + asm_word;
`endif
      end
    end
  end

endmodule
